// File: rtl/cpu_pkg.sv
// Shared sizing, opcode encoding and decoded-bundle definitions for the decode stage.
package cpu_pkg;

  localparam int unsigned NREGS  = 16;
  localparam int unsigned ADDR_W = 20;
  localparam logic [31:0] NOP    = 32'hF000_0000;

  typedef enum logic [3:0] {
    OpAluR  = 4'h0,
    OpAluI  = 4'h1,
    OpLoad  = 4'h2,
    OpStore = 4'h3,
    OpJmp   = 4'h4,
    OpJrel  = 4'h5,
    OpNop   = 4'hF
  } opcode_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } ex_bundle_t;

  function automatic logic is_illegal(logic [3:0] op);
    return (op >= 4'h6) && (op <= 4'hE);
  endfunction

  function automatic ex_bundle_t decode_instr(logic [31:0] instr);
    ex_bundle_t b;
    b.op      = instr[31:28];
    b.funct   = instr[3:0];
    b.rd      = instr[27:24];
    b.rs1     = instr[23:20];
    b.rs2     = instr[19:16];
    b.imm     = {{16{instr[15]}}, instr[15:0]};
    b.illegal = is_illegal(instr[31:28]);
    return b;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking: set on issue of a writer, cleared on writeback,
// with a two-source hazard lookup for the instruction waiting to issue.
module reg_scoreboard #(
  parameter int unsigned NREGS = 16,
  localparam int unsigned IdxW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_async_n,
  input  logic            set_en_i,
  input  logic [IdxW-1:0] set_idx_i,
  input  logic            clr_en_i,
  input  logic [IdxW-1:0] clr_idx_i,
  input  logic [IdxW-1:0] rs_a_i,
  input  logic            use_a_i,
  input  logic [IdxW-1:0] rs_b_i,
  input  logic            use_b_i,
  output logic            hazard_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    // Applied after the clear so a same-cycle issue and retire leave the bit set.
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    hazard_o = (use_a_i && busy_q[rs_a_i]) || (use_b_i && busy_q[rs_b_i]);
  end

endmodule

// File: rtl/i_decode.sv
// Decode stage: 2-entry PC-tagged instruction FIFO, jump resolution at the head,
// scoreboarded issue into a held output register toward execute.
module i_decode #(
  parameter int unsigned NREGS  = cpu_pkg::NREGS,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_async_n,
  input  logic [31:0]       instruction,
  output logic              fetch_en,
  output logic              load_en,
  output logic              load_offset,
  output logic [ADDR_W-1:0] load_address,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [3:0]        ex_op,
  output logic [3:0]        ex_funct,
  output logic [3:0]        ex_rd,
  output logic [3:0]        ex_rs1,
  output logic [3:0]        ex_rs2,
  output logic [31:0]       ex_imm,
  output logic              ex_illegal,
  input  logic              wb_en,
  input  logic [3:0]        wb_rd
);

  import cpu_pkg::*;

  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [31:0]       fifo_instr_q [2];
  logic [ADDR_W-1:0] fifo_pc_q [2];
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              squash_q;
  logic              load_en_q;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic              ex_valid_q, ex_valid_d;
  ex_bundle_t        ex_q, ex_d;

  logic [31:0]       head_instr;
  logic [ADDR_W-1:0] head_pc;
  ex_bundle_t        head;
  logic              head_valid;
  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              use_a, use_b, writes;
  logic [3:0]        rs_b;
  logic              hazard;
  logic              issue;
  logic              in_take;
  logic              enq;

  always_comb begin
    head_instr = fifo_instr_q[rd_ptr_q];
    head_pc    = fifo_pc_q[rd_ptr_q];
    head       = decode_instr(head_instr);
    head_valid = (count_q != 2'd0);

    use_a  = 1'b0;
    use_b  = 1'b0;
    writes = 1'b0;
    rs_b   = head.rs2;
    case (head.op)
      OpAluR: begin
        use_a  = 1'b1;
        use_b  = 1'b1;
        writes = 1'b1;
      end
      OpAluI, OpLoad: begin
        use_a  = 1'b1;
        writes = 1'b1;
      end
      OpStore: begin
        use_a = 1'b1;
        use_b = 1'b1;
        rs_b  = head.rd;
      end
      default: ;
    endcase

    // Jumps never reach execute; they are resolved here and flush younger words.
    redirect = head_valid && ((head.op == OpJmp) || (head.op == OpJrel));
    if (head.op == OpJmp) begin
      target = ADDR_W'(head_instr[19:0]);
    end else begin
      target = head_pc + ADDR_W'(1) + ADDR_W'(head_instr[19:0]);
    end

    issue   = head_valid && !redirect && !hazard && (!ex_valid_q || ex_ready);
    in_take = (instruction[31:28] != OpNop) && !squash_q && !redirect;
    enq     = in_take && ((count_q != 2'd2) || issue);

    if (redirect) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      pc_d     = target;
    end else begin
      count_d  = count_q + 2'(enq) - 2'(issue);
      rd_ptr_d = rd_ptr_q ^ issue;
      wr_ptr_d = wr_ptr_q ^ enq;
      pc_d     = enq ? pc_q + ADDR_W'(1) : pc_q;
    end

    load_addr_d = redirect ? target : load_addr_q;

    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (issue) begin
      ex_valid_d = 1'b1;
      ex_d       = head;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  reg_scoreboard #(
    .NREGS(NREGS)
  ) u_reg_scoreboard (
    .clk        (clk),
    .rst_async_n(rst_async_n),
    .set_en_i   (issue && writes && (head.rd != 4'd0)),
    .set_idx_i  (head.rd),
    .clr_en_i   (wb_en),
    .clr_idx_i  (wb_rd),
    .rs_a_i     (head.rs1),
    .use_a_i    (use_a),
    .rs_b_i     (rs_b),
    .use_b_i    (use_b),
    .hazard_o   (hazard)
  );

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      pc_q        <= '0;
      squash_q    <= 1'b0;
      load_en_q   <= 1'b0;
      load_addr_q <= '0;
      ex_valid_q  <= 1'b0;
      ex_q        <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= NOP;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      pc_q        <= pc_d;
      squash_q    <= redirect;
      load_en_q   <= redirect;
      load_addr_q <= load_addr_d;
      ex_valid_q  <= ex_valid_d;
      ex_q        <= ex_d;
      if (enq) begin
        fifo_instr_q[wr_ptr_q] <= instruction;
        fifo_pc_q[wr_ptr_q]    <= pc_q;
      end
    end
  end

  always_comb begin
    fetch_en     = (count_q == 2'd0);
    load_en      = load_en_q;
    load_offset  = 1'b0;
    load_address = load_addr_q;
    ex_valid     = ex_valid_q;
    ex_op        = ex_q.op;
    ex_funct     = ex_q.funct;
    ex_rd        = ex_q.rd;
    ex_rs1       = ex_q.rs1;
    ex_rs2       = ex_q.rs2;
    ex_imm       = ex_q.imm;
    ex_illegal   = ex_q.illegal;
  end

endmodule
